// File: rtl/seq_det_pkg.sv
// ============================================================================
// Module  : seq_det_pkg
// Purpose : Shared defaults and helpers for the programmable pattern detector.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_det_pkg;

    localparam int          c_max_len         = 8;
    localparam int          c_cnt_w           = 8;
    localparam logic [7:0]  c_default_pattern = 8'b0010_1101;
    localparam int          c_default_len     = 6;

    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Low `len` bits set; patterns are limited to 32 bits by this mask width.
    function automatic logic [31:0] window_mask(input int unsigned len);
        if (len >= 32)
            return '1;
        return (32'd1 << len) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Purpose : Saturating event counter; a clear coinciding with an event gives 1.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = inc_i ? CNT_W'(1) : '0;
        else if (inc_i && (count_q != '1))
            count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/seq_detector_prog.sv
// ============================================================================
// Module  : seq_detector_prog
// Purpose : Runtime-programmable serial pattern detector with Mealy match flag.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN         = c_max_len,
    parameter int                 LEN_W           = len_width(MAX_LEN),
    parameter int                 CNT_W           = c_cnt_w,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(c_default_pattern),
    parameter int                 DEFAULT_LEN     = c_default_len
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               clr_count,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   fill
);

    logic [MAX_LEN-1:0] pat_q,  pat_d;
    logic [LEN_W-1:0]   len_q,  len_d;
    logic               ovl_q,  ovl_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;

    logic [MAX_LEN-1:0] w_cand;
    logic [31:0]        w_mask;
    logic [31:0]        w_diff;
    logic               w_window_eq;
    logic               w_fill_ok;
    logic [LEN_W-1:0]   w_cfg_len_sat;
    logic [LEN_W-1:0]   w_fill_inc;

    // Newest bit sits at position 0, matching pattern bit 0 being the last received.
    assign w_cand      = {hist_q, in_bit};
    assign w_mask      = window_mask(32'(len_q));
    assign w_diff      = 32'(w_cand ^ pat_q);
    assign w_window_eq = ((w_diff & w_mask) == 32'd0);
    assign w_fill_ok   = (fill_q >= (len_q - LEN_W'(1)));

    assign match = reset & ~cfg_load & in_valid & (len_q != '0) & w_fill_ok & w_window_eq;

    assign w_cfg_len_sat = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
    assign w_fill_inc    = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);

    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = w_cfg_len_sat;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            if (match && !ovl_q) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = w_cand[MAX_LEN-2:0];
                fill_d = w_fill_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pat_q  <= DEFAULT_PATTERN;
            len_q  <= LEN_W'(DEFAULT_LEN);
            ovl_q  <= 1'b1;
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign fill = fill_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (clr_count),
        .inc_i   (match),
        .count_o (match_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_prog.sv
// ============================================================================
// Module  : tb_seq_detector_prog
// Purpose : Self-checking bench for seq_detector_prog (CNT_W=8 and CNT_W=2).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_detector_prog;

    localparam int ML = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic       clr_count = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       match, match_s;
    logic [7:0] match_count;
    logic [1:0] match_count_s;
    logic [3:0] fill, fill_s;

    int checks = 0;
    int failures = 0;

    seq_detector_prog dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .clr_count(clr_count),
        .in_valid(in_valid), .in_bit(in_bit), .match(match),
        .match_count(match_count), .fill(fill)
    );

    seq_detector_prog #(.CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .clr_count(clr_count),
        .in_valid(in_valid), .in_bit(in_bit), .match(match_s),
        .match_count(match_count_s), .fill(fill_s)
    );

    always #5 clk = ~clk;

    // Reference model: list of bits received since the last history clear.
    bit         m_hist[$];
    int         m_fill;
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_cnt, m_cnt_s;

    function automatic bit model_match(bit v, bit b);
        bit c;
        if (!v || m_len == 0) return 1'b0;
        if (m_fill < m_len - 1) return 1'b0;
        for (int j = 0; j < m_len; j++) begin
            c = (j == 0) ? b : m_hist[m_hist.size() - j];
            if (c != m_pat[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int exp_fill();
        return (m_fill > ML) ? ML : m_fill;
    endfunction

    // One clock cycle with the currently driven inputs; returns observed/expected match.
    task automatic cyc(output logic got_m, output logic got_ms, output bit exp_m);
        bit em;
        #1;
        em     = reset && !cfg_load && model_match(in_valid, in_bit);
        got_m  = match;
        got_ms = match_s;
        exp_m  = em;
        @(posedge clk);
        if (!reset) begin
            m_hist.delete(); m_fill = 0; m_pat = 8'b0010_1101; m_len = 6; m_ovl = 1'b1;
            m_cnt = 0; m_cnt_s = 0;
        end else begin
            if (clr_count) begin
                m_cnt = em; m_cnt_s = em;
            end else if (em) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt_s < 3) m_cnt_s++;
            end
            if (cfg_load) begin
                m_pat = cfg_pattern;
                m_len = (int'(cfg_len) > ML) ? ML : int'(cfg_len);
                m_ovl = cfg_overlap;
                m_hist.delete(); m_fill = 0;
            end else if (in_valid) begin
                if (em && !m_ovl) begin
                    m_hist.delete(); m_fill = 0;
                end else begin
                    m_hist.push_back(in_bit);
                    if (m_hist.size() > ML) void'(m_hist.pop_front());
                    m_fill++;
                end
            end
        end
        #1;
    endtask

    task automatic set_in(bit v, bit b, bit clr);
        cfg_load = 1'b0; in_valid = v; in_bit = b; clr_count = clr;
    endtask

    task automatic load_cfg(logic [7:0] p, logic [3:0] l, bit o, bit clr);
        cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        clr_count = clr; in_valid = 1'b1; in_bit = 1'b1;
    endtask

    task automatic do_reset(int n);
        logic g, gs; bit e;
        reset = 1'b0; set_in(1'b0, 1'b0, 1'b0);
        repeat (n) cyc(g, gs, e);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic g, gs; bit e;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'b1, 1'b0);
            cyc(g, gs, e);
            checks++;
            if (g !== 1'b0) begin failures++; $display("FAIL reset_match: got %b expected 0", g); end
        end
        reset = 1'b1;
        checks++;
        if (fill !== 4'd0) begin failures++; $display("FAIL reset_fill: got %0d expected 0", fill); end
        checks++;
        if (match_count !== 8'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", match_count); end
    endtask

    task automatic test_default_match();
        logic g, gs; bit e;
        bit seq[6] = '{1, 0, 1, 1, 0, 1};
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, seq[i], 1'b0);
            cyc(g, gs, e);
            checks++;
            if (g !== (i == 5)) begin failures++; $display("FAIL default_match bit%0d: got %b expected %b", i, g, i == 5); end
        end
        checks++;
        if (match_count !== 8'd1) begin failures++; $display("FAIL default_count: got %0d expected 1", match_count); end
        checks++;
        if (fill !== 4'd6) begin failures++; $display("FAIL default_fill: got %0d expected 6", fill); end
    endtask

    task automatic test_overlap_on();
        logic g, gs; bit e;
        bit seq[9] = '{1, 0, 1, 1, 0, 1, 1, 0, 1};
        do_reset(1);
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, seq[i], 1'b0);
            cyc(g, gs, e);
            checks++;
            if (g !== (i == 5 || i == 8)) begin failures++; $display("FAIL overlap_on bit%0d: got %b expected %b", i, g, i == 5 || i == 8); end
        end
        checks++;
        if (match_count !== 8'd2) begin failures++; $display("FAIL overlap_on_count: got %0d expected 2", match_count); end
    endtask

    task automatic test_overlap_off();
        logic g, gs; bit e;
        bit seq[9] = '{1, 0, 1, 1, 0, 1, 1, 0, 1};
        load_cfg(8'b0010_1101, 4'd6, 1'b0, 1'b1);
        cyc(g, gs, e);
        checks++;
        if (g !== 1'b0) begin failures++; $display("FAIL cfg_load_match: got %b expected 0", g); end
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, seq[i], 1'b0);
            cyc(g, gs, e);
            checks++;
            if (g !== (i == 5)) begin failures++; $display("FAIL overlap_off bit%0d: got %b expected %b", i, g, i == 5); end
            if (i == 5) begin
                checks++;
                if (fill !== 4'd0) begin failures++; $display("FAIL overlap_off_fill: got %0d expected 0", fill); end
            end
        end
        checks++;
        if (match_count !== 8'd1) begin failures++; $display("FAIL overlap_off_count: got %0d expected 1", match_count); end
    endtask

    task automatic test_gaps();
        logic g, gs; bit e;
        logic [3:0] f_before;
        bit seq[6] = '{1, 0, 1, 1, 0, 1};
        load_cfg(8'b0010_1101, 4'd6, 1'b1, 1'b1);
        cyc(g, gs, e);
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, seq[i], 1'b0);
            cyc(g, gs, e);
            checks++;
            if (g !== (i == 5)) begin failures++; $display("FAIL gaps bit%0d: got %b expected %b", i, g, i == 5); end
            if (i >= 1 && i <= 3) begin
                f_before = fill;
                set_in(1'b0, i[0], 1'b0);
                cyc(g, gs, e);
                checks++;
                if (g !== 1'b0) begin failures++; $display("FAIL gap_match: got %b expected 0", g); end
                checks++;
                if (fill !== f_before) begin failures++; $display("FAIL gap_fill: got %0d expected %0d", fill, f_before); end
            end
        end
        checks++;
        if (match_count !== 8'd1) begin failures++; $display("FAIL gaps_count: got %0d expected 1", match_count); end
    endtask

    task automatic test_reprogram();
        logic g, gs; bit e;
        bit seq[4] = '{0, 1, 1, 1};
        load_cfg(8'b0010_1101, 4'd6, 1'b1, 1'b1);
        cyc(g, gs, e);
        set_in(1'b1, 1'b1, 1'b0); cyc(g, gs, e);
        set_in(1'b1, 1'b0, 1'b0); cyc(g, gs, e);
        load_cfg(8'b0000_0011, 4'd3, 1'b1, 1'b0);
        cyc(g, gs, e);
        checks++;
        if (fill !== 4'd0) begin failures++; $display("FAIL reprogram_fill: got %0d expected 0", fill); end
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, seq[i], 1'b0);
            cyc(g, gs, e);
            checks++;
            if (g !== (i == 2)) begin failures++; $display("FAIL reprogram bit%0d: got %b expected %b", i, g, i == 2); end
        end
    endtask

    task automatic test_len_edges();
        logic g, gs; bit e;
        logic [7:0] p = 8'hA5;
        load_cfg(8'h00, 4'd0, 1'b1, 1'b1);
        cyc(g, gs, e);
        for (int i = 0; i < 30; i++) begin
            set_in(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            cyc(g, gs, e);
            checks++;
            if (g !== 1'b0) begin failures++; $display("FAIL len0 bit%0d: got %b expected 0", i, g); end
        end
        load_cfg(p, 4'd11, 1'b1, 1'b0);
        cyc(g, gs, e);
        for (int i = 7; i >= 0; i--) begin
            set_in(1'b1, p[i], 1'b0);
            cyc(g, gs, e);
            checks++;
            if (g !== (i == 0)) begin failures++; $display("FAIL len_sat bit%0d: got %b expected %b", i, g, i == 0); end
        end
        checks++;
        if (fill !== 4'd8) begin failures++; $display("FAIL fill_sat: got %0d expected 8", fill); end
    endtask

    task automatic test_counter();
        logic g, gs; bit e;
        load_cfg(8'h01, 4'd1, 1'b1, 1'b1);
        cyc(g, gs, e);
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b1, 1'b0);
            cyc(g, gs, e);
        end
        checks++;
        if (match_count_s !== 2'd3) begin failures++; $display("FAIL cnt_saturate: got %0d expected 3", match_count_s); end
        checks++;
        if (match_count !== 8'd5) begin failures++; $display("FAIL cnt_wide: got %0d expected 5", match_count); end
        set_in(1'b1, 1'b1, 1'b1);
        cyc(g, gs, e);
        checks++;
        if (match_count_s !== 2'd1) begin failures++; $display("FAIL cnt_clr_with_match: got %0d expected 1", match_count_s); end
        set_in(1'b0, 1'b1, 1'b1);
        cyc(g, gs, e);
        checks++;
        if (match_count_s !== 2'd0) begin failures++; $display("FAIL cnt_clr: got %0d expected 0", match_count_s); end
    endtask

    task automatic test_reset_mid();
        logic g, gs; bit e;
        bit seq[5] = '{1, 0, 1, 1, 0};
        load_cfg(8'b0010_1101, 4'd6, 1'b1, 1'b1);
        cyc(g, gs, e);
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, seq[i], 1'b0);
            cyc(g, gs, e);
        end
        reset = 1'b0; set_in(1'b1, 1'b1, 1'b0);
        cyc(g, gs, e);
        reset = 1'b1;
        cyc(g, gs, e);
        checks++;
        if (g !== 1'b0) begin failures++; $display("FAIL reset_mid_match: got %b expected 0", g); end
        checks++;
        if (match_count !== 8'd0) begin failures++; $display("FAIL reset_mid_count: got %0d expected 0", match_count); end
        checks++;
        if (fill !== 4'd1) begin failures++; $display("FAIL reset_mid_fill: got %0d expected 1", fill); end
    endtask

    task automatic test_random();
        logic g, gs; bit e;
        do_reset(1);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0)
                load_cfg(8'($urandom), ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 11)) : 4'($urandom_range(1, 3)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                set_in($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
            cyc(g, gs, e);
            checks++;
            if (g !== e) begin failures++; $display("FAIL rand_match cyc%0d: got %b expected %b", i, g, e); end
            checks++;
            if (gs !== e) begin failures++; $display("FAIL rand_match_s cyc%0d: got %b expected %b", i, gs, e); end
            checks++;
            if (fill !== 4'(exp_fill())) begin failures++; $display("FAIL rand_fill cyc%0d: got %0d expected %0d", i, fill, exp_fill()); end
            checks++;
            if (match_count !== 8'(m_cnt)) begin failures++; $display("FAIL rand_count cyc%0d: got %0d expected %0d", i, match_count, m_cnt); end
            checks++;
            if (match_count_s !== 2'(m_cnt_s)) begin failures++; $display("FAIL rand_count_s cyc%0d: got %0d expected %0d", i, match_count_s, m_cnt_s); end
        end
    endtask

    initial begin
        test_reset();
        test_default_match();
        test_overlap_on();
        test_overlap_off();
        test_gaps();
        test_reprogram();
        test_len_edges();
        test_counter();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
